// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming parity accumulator.
package parity_pkg;

  // Packet-level control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Width of a beat counter that must hold values 0..max_beats.
  function automatic int unsigned clog2_beats(input int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/xor_reduce_tree.sv
// Balanced XOR reduction of a WIDTH-bit word down to a single parity bit.
module xor_reduce_tree #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_c
);

  localparam int unsigned LVLS = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
  localparam int unsigned P    = 1 << LVLS;

  logic [P-1:0] tmp;

  // Pairwise fold, one tree level per outer iteration; zero padding is parity-neutral.
  always_comb begin
    tmp = P'(data_i);
    for (int l = 0; l < int'(LVLS); l++) begin
      for (int k = 0; k < int'(P >> (l + 1)); k++) begin
        tmp[k] = tmp[2*k] ^ tmp[2*k+1];
      end
    end
  end

  assign parity_c = tmp[0];

endmodule

// File: rtl/parity_stream_accum.sv
// Streaming parity accumulator: folds beats of a packet into one parity result
// and returns parity, check error, beat count and overflow over valid/ready.
module parity_stream_accum
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned ODD       = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_last,
  input  logic                                in_par,
  input  logic                                check_en,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_parity,
  output logic                                out_err,
  output logic [clog2_beats(MAX_BEATS)-1:0]   out_beats,
  output logic                                out_overflow
);

  localparam int unsigned CW = clog2_beats(MAX_BEATS);

  state_e          state_q, state_d;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            out_parity_q, out_parity_d;
  logic            out_err_q, out_err_d;
  logic [CW-1:0]   out_beats_q, out_beats_d;
  logic            out_overflow_q, out_overflow_d;

  logic            beat_par_c;
  logic            accept_c;
  logic            acc_next_c;
  logic [CW-1:0]   cnt_next_c;
  logic            at_max_c;
  logic            end_c;
  logic            par_res_c;

  // Per-beat parity.
  xor_reduce_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .data_i   (in_data),
    .parity_c (beat_par_c)
  );

  // Beat-level datapath shared by IDLE and ACCUM.
  always_comb begin
    accept_c   = in_valid && in_ready_q;
    acc_next_c = (state_q == IDLE) ? beat_par_c : (acc_q ^ beat_par_c);
    cnt_next_c = (state_q == IDLE) ? CW'(1) : CW'(cnt_q + CW'(1));
    at_max_c   = (cnt_next_c == CW'(MAX_BEATS));
    end_c      = in_last || at_max_c;
    par_res_c  = acc_next_c ^ 1'(ODD);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    out_valid_d    = out_valid_q;
    out_parity_d   = out_parity_q;
    out_err_d      = out_err_q;
    out_beats_d    = out_beats_q;
    out_overflow_d = out_overflow_q;

    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept_c) begin
          acc_d = acc_next_c;
          cnt_d = cnt_next_c;
          if (end_c) begin
            state_d        = HOLD;
            out_valid_d    = 1'b1;
            out_parity_d   = par_res_c;
            out_err_d      = check_en & (par_res_c ^ in_par);
            out_beats_d    = cnt_next_c;
            out_overflow_d = ~in_last & at_max_c;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d != HOLD);
  end

  // State and output registers; reset drops any partial packet or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= 1'b0;
      cnt_q          <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_parity_q   <= 1'b0;
      out_err_q      <= 1'b0;
      out_beats_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_parity_q   <= out_parity_d;
      out_err_q      <= out_err_d;
      out_beats_q    <= out_beats_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_parity   = out_parity_q;
  assign out_err      = out_err_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_parity_stream_accum.sv
// Directed bench for parity_stream_accum: three instances (even/16, odd/16, even/4).
module tb_parity_stream_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_par;
  logic       check_en;
  logic       out_ready;
  int         sel;

  logic [2:0] vld_v, rdy_v, ov_v, par_v, err_v, ovf_v;
  logic [4:0] beats0, beats1;
  logic [2:0] beats2;

  logic       obs_in_ready, obs_out_valid, obs_parity, obs_err, obs_ovf;
  logic [4:0] obs_beats;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) vld_v[i] = in_valid && (sel == i);
  end

  parity_stream_accum #(.WIDTH(8), .MAX_BEATS(16), .ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld_v[0]), .in_ready(rdy_v[0]),
    .in_data(in_data), .in_last(in_last), .in_par(in_par), .check_en(check_en),
    .out_valid(ov_v[0]), .out_ready(out_ready), .out_parity(par_v[0]),
    .out_err(err_v[0]), .out_beats(beats0), .out_overflow(ovf_v[0]));

  parity_stream_accum #(.WIDTH(8), .MAX_BEATS(16), .ODD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld_v[1]), .in_ready(rdy_v[1]),
    .in_data(in_data), .in_last(in_last), .in_par(in_par), .check_en(check_en),
    .out_valid(ov_v[1]), .out_ready(out_ready), .out_parity(par_v[1]),
    .out_err(err_v[1]), .out_beats(beats1), .out_overflow(ovf_v[1]));

  parity_stream_accum #(.WIDTH(8), .MAX_BEATS(4), .ODD(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld_v[2]), .in_ready(rdy_v[2]),
    .in_data(in_data), .in_last(in_last), .in_par(in_par), .check_en(check_en),
    .out_valid(ov_v[2]), .out_ready(out_ready), .out_parity(par_v[2]),
    .out_err(err_v[2]), .out_beats(beats2), .out_overflow(ovf_v[2]));

  // Observe the currently selected instance.
  always_comb begin
    obs_in_ready  = rdy_v[sel];
    obs_out_valid = ov_v[sel];
    obs_parity    = par_v[sel];
    obs_err       = err_v[sel];
    obs_ovf       = ovf_v[sel];
    case (sel)
      0:       obs_beats = beats0;
      1:       obs_beats = beats1;
      default: obs_beats = 5'(beats2);
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat from a negedge and return at the negedge after it is taken.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic par, input logic chk);
    int n = 0;
    in_data = d; in_last = last; in_par = par; check_en = chk; in_valid = 1'b1;
    while (!obs_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("accept_timeout", 32'(obs_in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Check a result that must be visible right after its end beat, then consume it.
  task automatic expect_result(input string tag, input logic p, input logic e,
                               input int b, input logic o);
    check_eq({tag, "_valid"}, 32'(obs_out_valid), 32'd1);
    check_eq({tag, "_parity"}, 32'(obs_parity), 32'(p));
    check_eq({tag, "_err"}, 32'(obs_err), 32'(e));
    check_eq({tag, "_beats"}, 32'(obs_beats), 32'(b));
    check_eq({tag, "_ovf"}, 32'(obs_ovf), 32'(o));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_drain_valid"}, 32'(obs_out_valid), 32'd0);
    check_eq({tag, "_drain_ready"}, 32'(obs_in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_par = 1'b0; check_en = 1'b0; out_ready = 1'b0; sel = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(obs_in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(obs_out_valid), 32'd0);
    check_eq("rst_beats", 32'(obs_beats), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(obs_in_ready), 32'd1);

    // 1: single beat A5 (four ones)
    send_beat(8'hA5, 1'b1, 1'b0, 1'b1);
    expect_result("t1", 1'b0, 1'b0, 1, 1'b0);

    // 2: 01,03,07 -> 1^0^1 = 0
    send_beat(8'h01, 1'b0, 1'b0, 1'b0);
    check_eq("t2_no_early_valid", 32'(obs_out_valid), 32'd0);
    send_beat(8'h03, 1'b0, 1'b0, 1'b0);
    send_beat(8'h07, 1'b1, 1'b0, 1'b1);
    expect_result("t2", 1'b0, 1'b0, 3, 1'b0);
    // same packet with in_par=1 flags an error
    send_beat(8'h01, 1'b0, 1'b0, 1'b0);
    send_beat(8'h03, 1'b0, 1'b0, 1'b0);
    send_beat(8'h07, 1'b1, 1'b1, 1'b1);
    expect_result("t2_err", 1'b0, 1'b1, 3, 1'b0);
    // odd instance
    sel = 1;
    send_beat(8'h01, 1'b0, 1'b0, 1'b0);
    send_beat(8'h03, 1'b0, 1'b0, 1'b0);
    send_beat(8'h07, 1'b1, 1'b0, 1'b1);
    expect_result("t2_odd", 1'b1, 1'b1, 3, 1'b0);

    // 3: overflow on MAX_BEATS=4 instance
    sel = 2;
    for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b0, 1'b0, 1'b0);
    expect_result("t3_cut", 1'b0, 1'b0, 4, 1'b1);
    send_beat(8'h01, 1'b1, 1'b0, 1'b0);
    expect_result("t3_next", 1'b1, 1'b0, 1, 1'b0);
    // last beat exactly at the limit is not overflow
    for (int i = 0; i < 3; i++) send_beat(8'h01, 1'b0, 1'b0, 1'b0);
    send_beat(8'h03, 1'b1, 1'b0, 1'b1);
    expect_result("t3_exact", 1'b1, 1'b1, 4, 1'b0);

    // 4: backpressure in HOLD with a stalled beat offered
    sel = 0;
    send_beat(8'h03, 1'b1, 1'b0, 1'b0);
    in_data = 8'hFF; in_last = 1'b1; in_par = 1'b0; check_en = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_stall_ready", 32'(obs_in_ready), 32'd0);
      check_eq("t4_hold_valid", 32'(obs_out_valid), 32'd1);
      check_eq("t4_hold_beats", 32'(obs_beats), 32'd1);
      check_eq("t4_hold_parity", 32'(obs_parity), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("t4_release_valid", 32'(obs_out_valid), 32'd0);
    check_eq("t4_release_ready", 32'(obs_in_ready), 32'd1);
    send_beat(8'hFF, 1'b1, 1'b0, 1'b0);
    expect_result("t4_next", 1'b0, 1'b0, 1, 1'b0);

    // 5: asynchronous reset after two beats
    send_beat(8'h01, 1'b0, 1'b0, 1'b0);
    send_beat(8'h01, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(obs_out_valid), 32'd0);
    check_eq("t5_rst_ready", 32'(obs_in_ready), 32'd0);
    check_eq("t5_rst_beats", 32'(obs_beats), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(8'hFF, 1'b1, 1'b0, 1'b0);
    expect_result("t5_next", 1'b0, 1'b0, 1, 1'b0);

    // 6: idle gaps between four beats of 80
    for (int i = 0; i < 4; i++) begin
      send_beat(8'h80, (i == 3), 1'b0, 1'b0);
      if (i < 3) begin
        @(negedge clk);
        check_eq("t6_gap_valid", 32'(obs_out_valid), 32'd0);
      end
    end
    expect_result("t6", 1'b0, 1'b0, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
